uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (tx core: byte, DV, ready, done) between NUM_REQ byte-stream requesters.
//  Round-robin arbitration is done per message, not per byte: the grant is held from the first byte to the byte flagged last.
//  Sits between the message feeders (string/status generators) and the single tx instance driving the serial pin.
// PARAMETERS
//  NUM_REQ      4    number of requester channels (2..8)
//  MAX_MSG_LEN  16   byte limit per message; on reaching it the message is force-ended
//  STALL_MAX    255  cycles a granted requester may leave req_valid low mid-message before abort
// PORTS
//  i_Clock    in   1           system clock, all logic on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  req_valid  in   NUM_REQ     requester k has a byte on req_data[8k+7:8k]
//  req_data   in   8*NUM_REQ   packed bytes, channel k at [8k+7:8k]
//  req_last   in   NUM_REQ     byte on channel k is the final byte of its message
//  req_ready  out  NUM_REQ     one-cycle pop strobe to the granted channel only
//  r_ready    in   1           downstream receiver flow control; low = do not start new bytes
//  tx_byte    out  8           byte to tx core
//  tx_dv      out  1           data-valid to tx core
//  tx_ready   in   1           tx core idle and able to accept
//  tx_done    in   1           tx core one-cycle pulse at end of stop bit
//  grant      out  NUM_REQ     one-hot owner of the transmitter, 0 when idle
//  busy       out  1           message in progress (state != IDLE)
//  msg_done   out  1           one-cycle pulse: message finished normally
//  msg_abort  out  1           one-cycle pulse: message ended by stall timeout or length limit
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, tx_dv=0, tx_byte=0, req_ready=0, busy=0, msg_done=0, msg_abort=0, rr_ptr=0, counters=0.
//  FSM states: IDLE, LOAD, SEND, WAIT_DONE.
//  IDLE: if |req_valid && r_ready, pick the first requester with req_valid set, searching from rr_ptr upward and wrapping.
//   Register grant. Go to LOAD (1 cycle after request).
//  LOAD: if req_valid[g] && tx_ready && r_ready:
//   - req_ready[g]=1 this cycle (combinational, single cycle).
//   - tx_byte<=req_data[g]; last_q<=req_last[g] | (byte_cnt==MAX_MSG_LEN-1).
//   - tx_dv<=1; byte_cnt++; stall_cnt<=0; go to SEND.
//   If req_valid[g] is low: stall_cnt++. When stall_cnt reaches STALL_MAX: pulse msg_abort, grant<=0, rr_ptr<=g+1, go to IDLE.
//   r_ready or tx_ready low: hold; stall_cnt is not incremented.
//  SEND: hold tx_dv=1 until tx_ready falls (core accepted), then tx_dv<=0 and go to WAIT_DONE. tx_byte is stable throughout.
//  WAIT_DONE: on tx_done:
//   - if last_q: grant<=0, rr_ptr<=(g+1) mod NUM_REQ, byte_cnt<=0, go to IDLE.
//     Pulse msg_done, or msg_abort instead if ended by the length limit with req_last low.
//   - else go to LOAD.
//  r_ready falling mid-byte: the in-flight byte completes; the next byte waits in LOAD.
//  Requests on non-granted channels are ignored; their req_ready is always 0.
//  A requester dropping req_valid after the grant is not revoked (stall rule applies).
//  Back-to-back messages: an IDLE cycle always separates them. The same requester may win again only if no other is valid.
//  byte_cnt width clog2(MAX_MSG_LEN+1); stall_cnt width clog2(STALL_MAX+1); no wrap possible.
//  Throughput: 1 byte per tx frame plus 2 cycles of arbiter overhead.
// STRUCTURE
//  Shared package uart_pkg: FSM state encoding, BYTE_W=8, tx handshake constants. The tx core reuses them.
//  Sub-module rr_arbiter: NUM_REQ req vector + pointer -> one-hot grant + index. Combinational, reusable.
//  This module: FSM, counters, output registers; instantiates rr_arbiter once.
// TESTING
//  1) Ch0 sends "Hi\n" (last on '\n'), r_ready=1 -> 3 frames 0x48,0x69,0x0A; msg_done once; grant 0001 then 0000.
//  2) Ch1 and ch3 valid in the same IDLE cycle, rr_ptr=0 -> ch1 is served fully, then ch3; rr_ptr ends at 0 (3+1 wraps to 0).
//  3) r_ready low after first byte accepted -> byte 1 completes; no tx_dv until r_ready high; remaining bytes intact.
//  4) Ch2 drops req_valid mid-message for STALL_MAX cycles -> msg_abort pulse, grant cleared, other requesters then served.
//  5) Ch0 streams 20 bytes with no last -> exactly 16 frames, msg_abort; the 17th byte starts a new message after re-arbitration.
//  6) rst_n low during SEND -> tx_dv, grant, busy at 0 within the same cycle; after release, IDLE with rr_ptr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, tx handshake
// levels and the arbiter FSM state encoding. The tx core uses the same package.
package uart_pkg;

    localparam int BYTE_W = 8;

    // Levels of the data-valid strobe toward the tx core
    localparam logic TX_DV_ON  = 1'b1;
    localparam logic TX_DV_OFF = 1'b0;

    // Message arbiter states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr (wrapping), as a one-hot vector and as an index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Scan from the farthest offset down so the nearest request to ptr wins
    always_comb begin
        int pos;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = int'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                gnt_idx  = IW'(pos);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx core between NUM_REQ byte-stream requesters. Arbitration
// is per message: a granted channel keeps the transmitter until its last byte,
// a length-limit cut, or a stall timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_MSG_LEN = 16,
    parameter int STALL_MAX   = 255
) (
    input  logic                      i_Clock,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      r_ready,
    output logic [BYTE_W-1:0]         tx_byte,
    output logic                      tx_dv,
    input  logic                      tx_ready,
    input  logic                      tx_done,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      msg_done,
    output logic                      msg_abort
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_MSG_LEN + 1);
    localparam int STL_W = $clog2(STALL_MAX + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [STL_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                last_q, last_d;
    logic                limit_q, limit_d;   // message cut by the length limit
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                tx_dv_q, tx_dv_d;
    logic                msg_done_q, msg_done_d;
    logic                msg_abort_q, msg_abort_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;
    logic                sel_valid;
    logic                sel_last;
    logic [BYTE_W-1:0]   sel_data;
    logic                at_limit;
    logic [IDX_W-1:0]    next_ptr;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign sel_valid = req_valid[gidx_q];
    assign sel_last  = req_last[gidx_q];
    assign sel_data  = req_data[gidx_q*BYTE_W +: BYTE_W];
    assign at_limit  = (byte_cnt_q == CNT_W'(MAX_MSG_LEN - 1));
    assign next_ptr  = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    assign grant     = grant_q;
    assign tx_byte   = tx_byte_q;
    assign tx_dv     = tx_dv_q;
    assign busy      = (state_q != ST_IDLE);
    assign msg_done  = msg_done_q;
    assign msg_abort = msg_abort_q;

    // Next-state logic, pop strobe and message-end pulses
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        stall_cnt_d = stall_cnt_q;
        last_d      = last_q;
        limit_d     = limit_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = tx_dv_q;
        msg_done_d  = 1'b0;
        msg_abort_d = 1'b0;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld && r_ready) begin
                    grant_d     = arb_gnt;
                    gidx_d      = arb_idx;
                    stall_cnt_d = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Flow control low freezes everything, including the stall timer
                if (r_ready && tx_ready) begin
                    if (sel_valid) begin
                        req_ready[gidx_q] = 1'b1;
                        tx_byte_d   = sel_data;
                        last_d      = sel_last | at_limit;
                        limit_d     = at_limit & ~sel_last;
                        tx_dv_d     = TX_DV_ON;
                        byte_cnt_d  = byte_cnt_q + 1'b1;
                        stall_cnt_d = '0;
                        state_d     = ST_SEND;
                    end else if (stall_cnt_q == STL_W'(STALL_MAX - 1)) begin
                        msg_abort_d = 1'b1;
                        grant_d     = '0;
                        rr_ptr_d    = next_ptr;
                        byte_cnt_d  = '0;
                        stall_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // tx_ready falling means the core has taken the byte
                if (!tx_ready) begin
                    tx_dv_d = TX_DV_OFF;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q) begin
                        grant_d    = '0;
                        rr_ptr_d   = next_ptr;
                        byte_cnt_d = '0;
                        if (limit_q) begin
                            msg_abort_d = 1'b1;
                        end else begin
                            msg_done_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
            last_q      <= 1'b0;
            limit_q     <= 1'b0;
            tx_byte_q   <= '0;
            tx_dv_q     <= TX_DV_OFF;
            msg_done_q  <= 1'b0;
            msg_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            last_q      <= last_d;
            limit_q     <= limit_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
            msg_done_q  <= msg_done_d;
            msg_abort_q <= msg_abort_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a tx-core model drive the
// DUT; a queue-level message model predicts frame order and message endings.
module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int MAXL   = 16;
    localparam int FRAME  = 8;
    localparam int BUDGET = 20000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           r_ready, tx_dv, tx_ready, tx_done, busy, msg_done, msg_abort;
    logic [7:0]     tx_byte;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_MSG_LEN(MAXL), .STALL_MAX(255)) dut (
        .i_Clock(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .r_ready(r_ready),
        .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_ready(tx_ready), .tx_done(tx_done),
        .grant(grant), .busy(busy), .msg_done(msg_done), .msg_abort(msg_abort)
    );

    logic [8:0] chq [N][$];          // live requester queues {last, byte}
    logic [8:0] mq  [N][$];          // model copy of the same traffic
    int obs_f[$], exp_f[$];          // frames: ch*256 + byte
    int obs_e[$], exp_e[$];          // events: ch (done) or 256 + ch (abort)
    int total = 0, bad = 0, viol = 0, mptr = 0, last_ch = 0, tx_cnt = 0;
    logic [N-1:0] first_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic drive();
        logic [8:0] e;
        for (int k = 0; k < N; k++) begin
            e = (chq[k].size() > 0) ? chq[k][0] : 9'h000;
            req_valid[k]        = (chq[k].size() > 0);
            req_last[k]         = e[8];
            req_data[8*k +: 8]  = e[7:0];
        end
    endtask

    // Requester pop handling, tx-core model and output monitor
    initial begin : env
        logic [N-1:0] pops;
        logic acc;
        forever begin
            @(negedge clk);
            pops = req_ready;
            acc  = tx_dv && tx_ready && rst_n;
            if (rst_n) begin
                if (((req_ready & ~grant) != '0) || ($countones(req_ready) > 1)) viol++;
                if (acc) begin
                    last_ch = onehot_idx(grant);
                    obs_f.push_back(last_ch * 256 + int'(tx_byte));
                end
                if (msg_done)  obs_e.push_back(last_ch);
                if (msg_abort) obs_e.push_back(256 + last_ch);
                if (grant != '0 && first_grant == '0) first_grant = grant;
            end
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!rst_n) begin
                tx_cnt   = 0;
                tx_ready = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (pops[k]) begin
                        if (chq[k].size() == 0) viol++;
                        else void'(chq[k].pop_front());
                    end
                end
                if (acc) begin
                    tx_ready = 1'b0;
                    tx_cnt   = FRAME;
                end else if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done  = 1'b1;
                        tx_ready = 1'b1;
                    end
                end
            end
            drive();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b, input logic last);
        chq[ch].push_back({last, b});
        mq[ch].push_back({last, b});
    endtask

    task automatic push_msg(input int ch, input int len, input logic with_last);
        for (int i = 0; i < len; i++)
            push_byte(ch, 8'($urandom_range(0, 255)), with_last && (i == len - 1));
    endtask

    // Message-level reference: serve whole messages round-robin from mptr,
    // cut at MAXL bytes, abort when a granted stream runs dry before its last byte
    task automatic model_run();
        int g, k, n;
        bit found, ended;
        logic [8:0] e;
        forever begin
            found = 0; g = 0;
            for (int off = N - 1; off >= 0; off--) begin
                k = (mptr + off) % N;
                if (mq[k].size() > 0) begin g = k; found = 1; end
            end
            if (!found) break;
            n = 0; ended = 0;
            while (!ended) begin
                if (mq[g].size() == 0) begin
                    exp_e.push_back(256 + g); ended = 1;
                end else begin
                    e = mq[g].pop_front();
                    exp_f.push_back(g * 256 + int'(e[7:0]));
                    n++;
                    if (e[8]) begin exp_e.push_back(g); ended = 1; end
                    else if (n == MAXL) begin exp_e.push_back(256 + g); ended = 1; end
                end
            end
            mptr = (g + 1) % N;
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (chq[k].size() > 0) return 0;
        return 1;
    endfunction

    task automatic finish_run(input string tag, input bit rand_rr);
        int cycles = 0;
        while (!(all_empty() && !busy && tx_cnt == 0 && tx_ready) && cycles < BUDGET) begin
            if (rand_rr) r_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
            cycles++;
        end
        r_ready = 1'b1;
        chk({tag, "_timeout"}, 32'(cycles < BUDGET), 32'd1);
        cyc(3);
        chk({tag, "_nframes"}, obs_f.size(), exp_f.size());
        for (int i = 0; i < obs_f.size() && i < exp_f.size(); i++)
            chk($sformatf("%s_frame%0d", tag, i), obs_f[i], exp_f[i]);
        chk({tag, "_nevents"}, obs_e.size(), exp_e.size());
        for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++)
            chk($sformatf("%s_event%0d", tag, i), obs_e[i], exp_e[i]);
        $display("run %s: frames=%0d events=%0d", tag, obs_f.size(), obs_e.size());
        obs_f.delete(); exp_f.delete(); obs_e.delete(); exp_e.delete();
    endtask

    task automatic run_and_check(input string tag, input bit rand_rr);
        first_grant = '0;
        model_run();
        finish_run(tag, rand_rr);
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0; r_ready = 1'b1; tx_ready = 1'b1; tx_done = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; first_grant = '0;
        cyc(3);
        chk("rst_grant", grant, 0);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_msg_done", msg_done, 0);
        chk("rst_msg_abort", msg_abort, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_busy", busy, 0);

        // "Hi\n" on channel 0
        push_byte(0, 8'h48, 1'b0); push_byte(0, 8'h69, 1'b0); push_byte(0, 8'h0A, 1'b1);
        run_and_check("hi", 1'b0);
        chk("hi_grant_first", first_grant, 4'b0001);
        chk("hi_grant_end", grant, 4'b0000);

        // Simultaneous requesters, then pointer wrap check
        push_msg(1, 2, 1'b1); push_msg(3, 3, 1'b1);
        run_and_check("pair13", 1'b0);
        push_msg(3, 1, 1'b1); push_msg(0, 2, 1'b1);
        run_and_check("wrap", 1'b0);

        // r_ready drops after the first byte is accepted
        push_msg(2, 4, 1'b1);
        first_grant = '0;
        model_run();
        n = 0;
        while (obs_f.size() < 1 && n < 200) begin cyc(1); n++; end
        r_ready = 1'b0;
        cyc(40);
        chk("rrdy_inflight_only", obs_f.size(), 1);
        chk("rrdy_tx_dv_low", tx_dv, 0);
        chk("rrdy_busy", busy, 1);
        r_ready = 1'b1;
        finish_run("rrdy", 1'b0);

        // Channel 2 runs dry mid-message; others wait until the stall abort
        push_msg(2, 2, 1'b0);
        first_grant = '0;
        model_run();
        n = 0;
        while (grant != 4'b0100 && n < 200) begin cyc(1); n++; end
        chk("stall_grant2", grant, 4'b0100);
        push_msg(0, 2, 1'b1); push_msg(1, 3, 1'b1);
        model_run();
        finish_run("stall", 1'b0);

        // 20-byte stream: cut at the length limit, tail is a new message
        push_msg(0, 20, 1'b1);
        run_and_check("maxlen", 1'b0);

        // Random traffic with random downstream flow control
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) begin
                n = $urandom_range(0, 2);
                for (int m = 0; m < n; m++) push_msg(k, $urandom_range(1, 20), 1'b1);
            end
            run_and_check($sformatf("rand%0d", r), 1'b1);
        end

        // Async reset during SEND, with the pointer left away from zero
        push_msg(2, 1, 1'b1);
        run_and_check("pre_rst", 1'b0);
        push_msg(1, 3, 1'b1);
        n = 0;
        while (tx_dv !== 1'b1 && n < 200) begin cyc(1); n++; end
        chk("rst_mid_send_seen", tx_dv, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx_dv", tx_dv, 0);
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        for (int k = 0; k < N; k++) begin chq[k].delete(); mq[k].delete(); end
        obs_f.delete(); obs_e.delete(); exp_f.delete(); exp_e.delete();
        mptr = 0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        push_msg(3, 2, 1'b1); push_msg(0, 2, 1'b1);
        run_and_check("post_arst", 1'b0);

        chk("ready_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
